// File: rtl/alu_shift_sequencer_pkg.sv
// Shared ALU definitions: sequencer states, shift/rotate mode codes and the
// ALU_LHS operation codes as driven on {AC5_LHS1, AC4_LHS0}.
package alu_shift_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

  localparam logic [1:0] MODE_LOGICAL   = 2'b00;
  localparam logic [1:0] MODE_ROTATE    = 2'b01;
  localparam logic [1:0] MODE_THRUCARRY = 2'b10;
  localparam logic [1:0] MODE_ARITH     = 2'b11;

  localparam logic [1:0] LHS_PASS = 2'b00;
  localparam logic [1:0] LHS_SHL  = 2'b01;
  localparam logic [1:0] LHS_SHR  = 2'b10;
  localparam logic [1:0] LHS_ZERO = 2'b11;

endpackage

// File: rtl/alu_shift_fill.sv
// Selects the bit shifted into the vacated position of the single-bit shift
// (LCarryIn of ALU_LHS) from the current value, carry, direction and mode.
module alu_shift_fill
  import alu_shift_sequencer_pkg::*;
(
  input  logic [7:0] value,
  input  logic       carry,
  input  logic       dir,
  input  logic [1:0] mode,
  output logic       fill
);

  // Only the end bits of the value ever feed the fill.
  logic unused_mid;
  assign unused_mid = ^value[6:1];

  always_comb begin
    // NOTE: default assignment first so every path drives fill and no latch is inferred.
    fill = 1'b0;
    case (mode)
      MODE_ROTATE:    fill = dir ? value[0] : value[7];
      MODE_THRUCARRY: fill = carry;
      MODE_ARITH:     fill = dir ? value[7] : 1'b0;
      default:        fill = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-bit shift/rotate controller: issues Count single-bit shifts to ALU_LHS,
// feeding each registered result back as the next LHS, then pulses Done.
module alu_shift_sequencer
  import alu_shift_sequencer_pkg::*;
(
  input  logic       AluClock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Operand,
  input  logic [2:0] Count,
  input  logic       Dir,
  input  logic [1:0] Mode,
  input  logic       CarryIn,
  output logic [7:0] LHS,
  output logic       AC4_LHS0,
  output logic       AC5_LHS1,
  output logic       LCarryIn,
  input  logic [7:0] Shift,
  input  logic       LCarryOut,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Result,
  output logic       CarryOut
);

  state_t     state, state_next;
  logic [7:0] value_q;
  logic       carry_q;
  logic [2:0] remaining_q;
  logic       dir_q;
  logic [1:0] mode_q;
  logic       fill;
  logic       accept;
  logic       last_capture;

  assign accept       = (state == ST_IDLE) && Start;
  assign last_capture = (state == ST_CAPTURE) && (remaining_q == 3'd1);

  alu_shift_fill u_fill (
    .value (value_q),
    .carry (carry_q),
    .dir   (dir_q),
    .mode  (mode_q),
    .fill  (fill)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge AluClock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (Start) state_next = (Count == 3'd0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE:   state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = (remaining_q == 3'd1) ? ST_DONE : ST_ISSUE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Result/CarryOut load on the edge entering DONE, from the same values the
  // value/carry registers take on that edge.
  always_ff @(posedge AluClock) begin
    if (Reset) begin
      value_q     <= 8'h00;
      carry_q     <= 1'b0;
      remaining_q <= 3'd0;
      dir_q       <= 1'b0;
      mode_q      <= MODE_LOGICAL;
      Result      <= 8'h00;
      CarryOut    <= 1'b0;
    end else if (accept) begin
      value_q     <= Operand;
      carry_q     <= CarryIn;
      remaining_q <= Count;
      dir_q       <= Dir;
      mode_q      <= Mode;
      if (Count == 3'd0) begin
        Result   <= Operand;
        CarryOut <= CarryIn;
      end
    end else if (state == ST_CAPTURE) begin
      value_q     <= Shift;
      carry_q     <= LCarryOut;
      remaining_q <= remaining_q - 3'd1;
      if (last_capture) begin
        Result   <= Shift;
        CarryOut <= LCarryOut;
      end
    end
  end

  always_comb begin
    LHS      = value_q;
    AC4_LHS0 = 1'b0;
    AC5_LHS1 = 1'b0;
    LCarryIn = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state)
      ST_ISSUE, ST_CAPTURE: begin
        {AC5_LHS1, AC4_LHS0} = dir_q ? LHS_SHR : LHS_SHL;
        LCarryIn             = fill;
        Busy                 = 1'b1;
      end
      ST_DONE: Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Bench for alu_shift_sequencer with a behavioural ALU_LHS responder, a table of
// directed vectors, hand-written hold/reset sequences and randomized operations.
module tb_alu_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] operand;
  logic [2:0] count;
  logic       dir;
  logic [1:0] mode;
  logic       cin;
  logic [7:0] lhs;
  logic       ac4, ac5, lci;
  logic [7:0] shift;
  logic       lco;
  logic       busy, done;
  logic [7:0] result;
  logic       cout;

  int vectors     = 0;
  int miscompares = 0;
  int done_count  = 0;
  bit both_seen   = 0;
  bit issue_seen  = 0;

  always #5 clk = ~clk;

  alu_shift_sequencer dut (
    .AluClock  (clk),
    .Reset     (rst),
    .Start     (start),
    .Operand   (operand),
    .Count     (count),
    .Dir       (dir),
    .Mode      (mode),
    .CarryIn   (cin),
    .LHS       (lhs),
    .AC4_LHS0  (ac4),
    .AC5_LHS1  (ac5),
    .LCarryIn  (lci),
    .Shift     (shift),
    .LCarryOut (lco),
    .Busy      (busy),
    .Done      (done),
    .Result    (result),
    .CarryOut  (cout)
  );

  // ALU_LHS responder: registered single-bit shifter selected by {AC5, AC4}.
  always @(posedge clk) begin
    if (rst) begin
      shift <= 8'h00;
      lco   <= 1'b0;
    end else begin
      case ({ac5, ac4})
        2'b00:   begin shift <= lhs;               lco <= 1'b0;   end
        2'b01:   begin shift <= {lhs[6:0], lci};   lco <= lhs[7]; end
        2'b10:   begin shift <= {lci, lhs[7:1]};   lco <= lhs[0]; end
        default: begin shift <= 8'h00;             lco <= 1'b0;   end
      endcase
    end
  end

  always @(negedge clk) begin
    if (done) done_count++;
    if (ac4 && ac5) both_seen = 1;
    if (ac4 || ac5) issue_seen = 1;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: apply the shift rule count times with plain integer arithmetic.
  function automatic void model(input logic [7:0] op, input logic [2:0] cnt, input logic d,
                                input logic [1:0] m, input logic ci,
                                output logic [7:0] r, output logic c);
    int v = op;
    int cy = ci;
    int fill;
    for (int i = 0; i < cnt; i++) begin
      case (m)
        2'b01:   fill = d ? (v % 2) : (v / 128);
        2'b10:   fill = cy;
        2'b11:   fill = d ? (v / 128) : 0;
        default: fill = 0;
      endcase
      if (d) begin
        cy = v % 2;
        v  = (v / 2) + fill * 128;
      end else begin
        cy = v / 128;
        v  = ((v * 2) % 256) + fill;
      end
    end
    r = 8'(v);
    c = cy[0];
  endfunction

  task automatic run_op(input logic [7:0] op, input logic [2:0] cnt, input logic d,
                        input logic [1:0] m, input logic ci, input bit hold,
                        output logic [7:0] r, output logic c, output int dc);
    @(negedge clk);
    operand = op; count = cnt; dir = d; mode = m; cin = ci; start = 1'b1;
    both_seen = 0; issue_seen = 0;
    @(posedge clk);
    dc = 0; r = 8'h00; c = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      operand = 8'($urandom); count = 3'($urandom); dir = 1'($urandom);
      mode = 2'($urandom); cin = 1'($urandom);
      if (done) begin
        dc = cyc; r = result; c = cout; start = 1'b0;
        break;
      end
    end
    if (dc == 0) check("done_timeout", 32'(0), 32'(1));
  endtask

  typedef struct {
    logic [7:0] op;
    logic [2:0] cnt;
    logic       d;
    logic [1:0] m;
    logic       ci;
    logic [7:0] exp_r;
    logic       exp_c;
    int         exp_dc;
  } vec_t;

  vec_t       table_v[5];
  logic [7:0] r, er;
  logic       c, ec;
  int         dc, base;

  initial begin
    table_v[0] = '{8'h81, 3'd1, 1'b0, 2'b00, 1'b0, 8'h02, 1'b1, 3};
    table_v[1] = '{8'h81, 3'd3, 1'b1, 2'b01, 1'b0, 8'h30, 1'b0, 7};
    table_v[2] = '{8'h80, 3'd2, 1'b0, 2'b10, 1'b0, 8'h01, 1'b0, 5};
    table_v[3] = '{8'h80, 3'd7, 1'b1, 2'b11, 1'b0, 8'hFF, 1'b0, 15};
    table_v[4] = '{8'h5A, 3'd0, 1'b0, 2'b00, 1'b1, 8'h5A, 1'b1, 1};

    rst = 1'b1; start = 1'b0; operand = 8'h00; count = 3'd0; dir = 1'b0; mode = 2'b00; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy_done", 32'({busy, done}), 32'(0));
    check("reset_result", 32'({cout, result}), 32'(0));
    check("reset_shifter_ctl", 32'({lhs, ac4, ac5, lci}), 32'(0));
    rst = 1'b0;

    foreach (table_v[i]) begin
      run_op(table_v[i].op, table_v[i].cnt, table_v[i].d, table_v[i].m, table_v[i].ci, 0, r, c, dc);
      check($sformatf("vec%0d_result", i), 32'(r), 32'(table_v[i].exp_r));
      check($sformatf("vec%0d_carry", i), 32'(c), 32'(table_v[i].exp_c));
      check($sformatf("vec%0d_done_cycle", i), 32'(dc), 32'(table_v[i].exp_dc));
      check($sformatf("vec%0d_ac_both", i), 32'(both_seen), 32'(0));
      check($sformatf("vec%0d_issued", i), 32'(issue_seen), 32'(table_v[i].cnt != 3'd0));
      @(negedge clk);
      check($sformatf("vec%0d_result_hold", i), 32'({cout, result}), 32'({table_v[i].exp_c, table_v[i].exp_r}));
    end

    // Start held high for a whole Count 4 operation: exactly one Done.
    base = done_count;
    run_op(8'h3C, 3'd4, 1'b0, 2'b00, 1'b0, 1, r, c, dc);
    repeat (6) @(negedge clk);
    check("hold_start_done_count", 32'(done_count - base), 32'(1));
    check("hold_start_result", 32'({c, r}), 32'({1'b1, 8'hC0}));

    // Reset in cycle 4 of a Count 4 operation, with Start also high.
    @(negedge clk);
    operand = 8'h0F; count = 3'd4; dir = 1'b1; mode = 2'b01; cin = 1'b0; start = 1'b1;
    base = done_count;
    @(posedge clk);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 4) begin rst = 1'b1; start = 1'b1; end
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("midreset_busy_done", 32'({busy, done}), 32'(0));
    check("midreset_result", 32'({cout, result}), 32'(0));
    check("midreset_shifter_ctl", 32'({lhs, ac4, ac5, lci}), 32'(0));
    repeat (12) @(negedge clk);
    check("midreset_no_done", 32'(done_count - base), 32'(0));

    model(8'h96, 3'd5, 1'b1, 2'b11, 1'b1, er, ec);
    run_op(8'h96, 3'd5, 1'b1, 2'b11, 1'b1, 0, r, c, dc);
    check("post_reset_result", 32'({c, r}), 32'({ec, er}));
    check("post_reset_done_cycle", 32'(dc), 32'(11));

    // Randomized back-to-back operations against the reference model.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] op  = 8'($urandom);
      logic [2:0] cnt = 3'($urandom);
      logic       d   = 1'($urandom);
      logic [1:0] m   = 2'($urandom);
      logic       ci  = 1'($urandom);
      model(op, cnt, d, m, ci, er, ec);
      run_op(op, cnt, d, m, ci, 0, r, c, dc);
      check($sformatf("rand%0d_result", n), 32'({c, r}), 32'({ec, er}));
      check($sformatf("rand%0d_done_cycle", n), 32'(dc), 32'(2 * cnt + 1));
      check($sformatf("rand%0d_ac_both", n), 32'(both_seen), 32'(0));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
